// File: rtl/cond_branch_ctrl_pkg.sv
// Shared condition codes, FSM state encoding and counter helpers for the conditional branch controller.
package cond_branch_ctrl_pkg;

    localparam logic [1:0] COND_GT = 2'b00;
    localparam logic [1:0] COND_LT = 2'b01;
    localparam logic [1:0] COND_EQ = 2'b10;
    localparam logic [1:0] COND_AL = 2'b11;

    localparam int WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FLAGS = 2'd1,
        EVAL       = 2'd2,
        REDIRECT   = 2'd3
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cond_branch_ctrl_cond_eval.sv
// Combinational branch predicate: condition code plus N/Z flags -> condition true.
module cond_eval
    import cond_branch_ctrl_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       flag_n,
    input  logic       flag_z,
    output logic       cond_true
);

    // Decode the condition code against the supplied flags
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_GT: cond_true = ~flag_n;
            COND_LT: cond_true = flag_n;
            COND_EQ: cond_true = flag_z;
            COND_AL: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_ctrl.sv
// Conditional branch controller: flag register, wait-for-flags FSM and PC-load/flush strobes.
// Optional build macro COND_BRANCH_STATS_EN adds saturating taken/not-taken/wait-cycle counters.
module cond_branch_ctrl
    import cond_branch_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int WAIT_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flag_we,
    input  logic              alu_negative,
    input  logic              alu_zero,
    input  logic              flag_pending,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [1:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              done,
    output logic              taken,
    output logic              wait_timeout
`ifdef COND_BRANCH_STATS_EN
    ,
    output logic [15:0]       stat_taken,
    output logic [15:0]       stat_not_taken,
    output logic [15:0]       stat_wait_cycles
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_LIMIT - 1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE  = WAIT_CNT_W'(1);

    state_t                  state_r, state_next_s;
    logic [1:0]              cond_r, cond_next_s;
    logic                    flag_n_r, flag_z_r, flag_n_next_s, flag_z_next_s;
    logic [WAIT_CNT_W-1:0]   wait_cnt_r, wait_cnt_next_s;
    logic [ADDR_W-1:0]       pc_target_r, pc_target_next_s;
    logic                    timeout_next_s;
    logic                    pred_cur_s, pred_next_s;
    logic                    br_ready_r, pc_load_r, flush_r, done_r, taken_r, wait_timeout_r;

    cond_eval u_eval_cur (
        .cond      (cond_r),
        .flag_n    (flag_n_r),
        .flag_z    (flag_z_r),
        .cond_true (pred_cur_s)
    );

    // Same predicate on next-cycle values lets the EVAL-cycle done/taken come straight from flops
    cond_eval u_eval_next (
        .cond      (cond_next_s),
        .flag_n    (flag_n_next_s),
        .flag_z    (flag_z_next_s),
        .cond_true (pred_next_s)
    );

    // Next-state, flag update and wait-counter logic
    always_comb begin
        state_next_s     = state_r;
        cond_next_s      = cond_r;
        pc_target_next_s = pc_target_r;
        wait_cnt_next_s  = {WAIT_CNT_W{1'b0}};
        timeout_next_s   = 1'b0;
        flag_n_next_s    = flag_n_r;
        flag_z_next_s    = flag_z_r;

        if (flag_we) begin
            flag_n_next_s = alu_negative;
            flag_z_next_s = alu_zero;
        end else begin
            flag_n_next_s = flag_n_r;
            flag_z_next_s = flag_z_r;
        end

        case (state_r)
            IDLE: begin
                if (br_valid) begin
                    cond_next_s      = br_cond;
                    pc_target_next_s = br_target;
                    if (br_cond == COND_AL) begin
                        state_next_s = REDIRECT;
                    end else if (flag_pending || flag_we) begin
                        state_next_s = WAIT_FLAGS;
                    end else begin
                        state_next_s = EVAL;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_FLAGS: begin
                if (!flag_pending) begin
                    state_next_s = EVAL;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s   = EVAL;
                    timeout_next_s = 1'b1;
                end else begin
                    state_next_s    = WAIT_FLAGS;
                    wait_cnt_next_s = wait_cnt_r + WAIT_ONE;
                end
            end
            EVAL: begin
                if (pred_cur_s) begin
                    state_next_s = REDIRECT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REDIRECT: state_next_s = IDLE;
            default:  state_next_s = IDLE;
        endcase
    end

    // State, flag and output registers; outputs are loaded with the decode of the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            cond_r         <= COND_GT;
            flag_n_r       <= 1'b0;
            flag_z_r       <= 1'b0;
            wait_cnt_r     <= {WAIT_CNT_W{1'b0}};
            pc_target_r    <= {ADDR_W{1'b0}};
            br_ready_r     <= 1'b1;
            pc_load_r      <= 1'b0;
            flush_r        <= 1'b0;
            done_r         <= 1'b0;
            taken_r        <= 1'b0;
            wait_timeout_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            cond_r         <= cond_next_s;
            flag_n_r       <= flag_n_next_s;
            flag_z_r       <= flag_z_next_s;
            wait_cnt_r     <= wait_cnt_next_s;
            pc_target_r    <= pc_target_next_s;
            br_ready_r     <= (state_next_s == IDLE);
            pc_load_r      <= (state_next_s == REDIRECT);
            flush_r        <= (state_next_s == REDIRECT);
            done_r         <= (state_next_s == REDIRECT) || ((state_next_s == EVAL) && !pred_next_s);
            taken_r        <= (state_next_s == REDIRECT);
            wait_timeout_r <= timeout_next_s;
        end
    end

    assign br_ready     = br_ready_r;
    assign pc_load      = pc_load_r;
    assign pc_target    = pc_target_r;
    assign flush        = flush_r;
    assign done         = done_r;
    assign taken        = taken_r;
    assign wait_timeout = wait_timeout_r;

`ifdef COND_BRANCH_STATS_EN
    logic [15:0] stat_taken_r, stat_not_taken_r, stat_wait_cycles_r;

    // Saturating event counters driven by the registered strobes and state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_taken_r       <= 16'd0;
            stat_not_taken_r   <= 16'd0;
            stat_wait_cycles_r <= 16'd0;
        end else begin
            if (done_r && taken_r) begin
                stat_taken_r <= sat_inc16(stat_taken_r);
            end
            if (done_r && !taken_r) begin
                stat_not_taken_r <= sat_inc16(stat_not_taken_r);
            end
            if (state_r == WAIT_FLAGS) begin
                stat_wait_cycles_r <= sat_inc16(stat_wait_cycles_r);
            end
        end
    end

    assign stat_taken       = stat_taken_r;
    assign stat_not_taken   = stat_not_taken_r;
    assign stat_wait_cycles = stat_wait_cycles_r;
`endif

endmodule

// File: tb/tb_cond_branch_ctrl.sv
// Self-checking bench for cond_branch_ctrl: table-driven branches with a result scoreboard plus
// hand-written wait, timeout, back-to-back and mid-operation reset sequences.
module tb_cond_branch_ctrl;
    import cond_branch_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flag_we = 1'b0, alu_negative = 1'b0, alu_zero = 1'b0, flag_pending = 1'b0;
    logic       br_valid = 1'b0;
    logic [1:0] br_cond = 2'b00;
    logic [7:0] br_target = 8'h00;

    logic       br_ready, pc_load, flush, done, taken, wait_timeout;
    logic [7:0] pc_target;
    logic       br_ready_lim, pc_load_lim, flush_lim, done_lim, taken_lim, wait_timeout_lim;
    logic [7:0] pc_target_lim;
`ifdef COND_BRANCH_STATS_EN
    logic [15:0] st_t, st_nt, st_w, st_t_lim, st_nt_lim, st_w_lim;
`endif

    cond_branch_ctrl #(.ADDR_W(8), .WAIT_LIMIT(15)) dut (
        .clk(clk), .reset(reset), .flag_we(flag_we), .alu_negative(alu_negative),
        .alu_zero(alu_zero), .flag_pending(flag_pending), .br_valid(br_valid),
        .br_ready(br_ready), .br_cond(br_cond), .br_target(br_target), .pc_load(pc_load),
        .pc_target(pc_target), .flush(flush), .done(done), .taken(taken),
        .wait_timeout(wait_timeout)
`ifdef COND_BRANCH_STATS_EN
        , .stat_taken(st_t), .stat_not_taken(st_nt), .stat_wait_cycles(st_w)
`endif
    );

    cond_branch_ctrl #(.ADDR_W(8), .WAIT_LIMIT(3)) dut_lim (
        .clk(clk), .reset(reset), .flag_we(flag_we), .alu_negative(alu_negative),
        .alu_zero(alu_zero), .flag_pending(flag_pending), .br_valid(br_valid),
        .br_ready(br_ready_lim), .br_cond(br_cond), .br_target(br_target), .pc_load(pc_load_lim),
        .pc_target(pc_target_lim), .flush(flush_lim), .done(done_lim), .taken(taken_lim),
        .wait_timeout(wait_timeout_lim)
`ifdef COND_BRANCH_STATS_EN
        , .stat_taken(st_t_lim), .stat_not_taken(st_nt_lim), .stat_wait_cycles(st_w_lim)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       taken;
        logic [7:0] target;
        int         lat;
        int         acc;
    } exp_t;

    typedef struct {
        logic       n;
        logic       z;
        logic [1:0] cond;
        logic [7:0] target;
        logic       exp_taken;
        int         exp_lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   compared = 0;
    int   failed = 0;
    int   cyc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, got, want, cyc);
        end
    endtask

    // Observe the current cycle at the falling edge, then advance to just after the next rising edge
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            if (pc_load || flush) begin
                compared++;
                if (!(pc_load && flush && done && taken)) begin
                    failed++;
                    $display("FAIL strobe_group: got pc_load=%b flush=%b done=%b taken=%b want all 1 (cyc %0d)",
                             pc_load, flush, done, taken, cyc);
                end
            end
            if (wait_timeout) begin
                compared++;
                failed++;
                $display("FAIL main_wait_timeout: got 1 want 0 (cyc %0d)", cyc);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    compared++;
                    failed++;
                    $display("FAIL unexpected_done: got done=1 want 0 (cyc %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("taken", taken, e.taken);
                    chk("pc_load_at_done", pc_load, e.taken);
                    chk("pc_target", pc_target, e.target);
                    chk("latency", cyc - e.acc + 1, e.lat);
                end
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic set_flags(input logic n, input logic z);
        flag_we = 1'b1;
        alu_negative = n;
        alu_zero = z;
        step();
        flag_we = 1'b0;
    endtask

    task automatic branch(input logic [1:0] cond, input logic [7:0] target, input logic push,
                          input logic exp_taken, input int exp_lat, output int acc);
        int guard;
        guard = 0;
        while (!br_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!br_ready) begin
            compared++;
            failed++;
            $display("FAIL br_ready_wait: got 0 want 1 within 50 cycles");
        end
        br_valid = 1'b1;
        br_cond = cond;
        br_target = target;
        step();
        acc = cyc;
        br_valid = 1'b0;
        br_cond = 2'($urandom);
        br_target = 8'($urandom);
        if (push) sb.push_back('{exp_taken, target, exp_lat, acc});
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 60) begin
            step();
            guard++;
        end
        if (sb.size() != 0) begin
            compared++;
            failed++;
            $display("FAIL drain_timeout: got %0d outstanding results want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int acc0, acc1;
        vecs[0] = '{1'b0, 1'b0, COND_AL, 8'h3C, 1'b1, 1};
        vecs[1] = '{1'b1, 1'b0, COND_LT, 8'h10, 1'b1, 2};
        vecs[2] = '{1'b0, 1'b0, COND_EQ, 8'h55, 1'b0, 1};
        vecs[3] = '{1'b0, 1'b0, COND_GT, 8'hA0, 1'b1, 2};
        vecs[4] = '{1'b1, 1'b0, COND_GT, 8'hA1, 1'b0, 1};
        vecs[5] = '{1'b0, 1'b1, COND_EQ, 8'h77, 1'b1, 2};
        vecs[6] = '{1'b0, 1'b1, COND_LT, 8'h78, 1'b0, 1};
        vecs[7] = '{1'b1, 1'b1, COND_AL, 8'hFF, 1'b1, 1};
        vecs[8] = '{1'b1, 1'b1, COND_EQ, 8'h00, 1'b1, 2};
        vecs[9] = '{1'b0, 1'b1, COND_GT, 8'h01, 1'b1, 2};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_br_ready", br_ready, 1);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_flush", flush, 0);
        chk("rst_done", done, 0);
        chk("rst_taken", taken, 0);
        chk("rst_wait_timeout", wait_timeout, 0);
        chk("rst_pc_target", pc_target, 0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            set_flags(vecs[i].n, vecs[i].z);
            branch(vecs[i].cond, vecs[i].target, 1'b1, vecs[i].exp_taken, vecs[i].exp_lat, acc0);
            drain();
        end

        // Back-to-back ALWAYS: ready drops for one cycle, accepts two cycles apart
        branch(COND_AL, 8'h11, 1'b1, 1'b1, 1, acc0);
        chk("b2b_ready_c1", br_ready, 0);
        branch(COND_AL, 8'h22, 1'b1, 1'b1, 1, acc1);
        chk("b2b_al_spacing", acc1 - acc0, 2);
        drain();

        // Back-to-back conditional taken: three cycles apart
        set_flags(1'b1, 1'b0);
        branch(COND_LT, 8'h21, 1'b1, 1'b1, 2, acc0);
        branch(COND_LT, 8'h22, 1'b1, 1'b1, 2, acc1);
        chk("b2b_cond_spacing", acc1 - acc0, 3);
        drain();

        // Accept during pending; Z written in the third wait cycle, pending drops in the fourth
        set_flags(1'b0, 1'b0);
        flag_pending = 1'b1;
        branch(COND_EQ, 8'h42, 1'b1, 1'b1, 6, acc0);
        step();
        chk("wait_ready_low", br_ready, 0);
        step();
        flag_we = 1'b1;
        alu_zero = 1'b1;
        step();
        flag_we = 1'b0;
        alu_zero = 1'b0;
        flag_pending = 1'b0;
        drain();
        repeat (4) step();

        // Stuck pending: the WAIT_LIMIT=3 instance times out and evaluates stale N=0 as not taken
        set_flags(1'b0, 1'b0);
        flag_pending = 1'b1;
        branch(COND_LT, 8'hC3, 1'b1, 1'b0, 8, acc0);
        for (int k = 1; k <= 7; k++) begin
            if (k == 7) flag_pending = 1'b0;
            if (k <= 5) begin
                chk("lim_wait_timeout", wait_timeout_lim, (k == 4));
                chk("lim_done", done_lim, (k == 4));
            end
            if (k == 4) begin
                chk("lim_taken", taken_lim, 0);
                chk("lim_pc_load", pc_load_lim, 0);
            end
            step();
        end
        drain();

        // Reset while waiting: immediate return to reset outputs, no strobe afterwards, flags cleared
        set_flags(1'b0, 1'b1);
        flag_pending = 1'b1;
        branch(COND_EQ, 8'h99, 1'b0, 1'b0, 0, acc0);
        step();
        reset = 1'b1;
        #1;
        chk("midrst_br_ready", br_ready, 1);
        chk("midrst_pc_load", pc_load, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pc_target", pc_target, 0);
        chk("midrst_lim_br_ready", br_ready_lim, 1);
        chk("midrst_lim_flush", flush_lim, 0);
        chk("midrst_lim_pc_target", pc_target_lim, 0);
        flag_pending = 1'b0;
        step();
        step();
        reset = 1'b0;
        repeat (8) step();
        branch(COND_EQ, 8'h5A, 1'b1, 1'b0, 1, acc0);
        drain();
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/cond_branch_ctrl.md
Name: cond_branch_ctrl

Overview:
Sequences conditional control transfers for the processor core. Holds the architectural N/Z flag register and accepts branch requests from decode over a valid/ready handshake. Waits out in-flight flag writers, evaluates the 2-bit condition code, and drives the PC-load and pipeline-flush strobes toward fetch. Sits between decode, the ALU flag outputs and the PC register.

Parameters:
ADDR_W, 8, width of branch target and PC.
WAIT_LIMIT, 15, max cycles spent in WAIT_FLAGS before forced evaluation (1..255).

Ports:
clk  in  1  core clock; all state on rising edge.
reset  in  1  asynchronous, active-high reset.
flag_we  in  1  ALU flag write strobe.
alu_negative  in  1  ALU N result, captured when flag_we=1.
alu_zero  in  1  ALU Z result, captured when flag_we=1.
flag_pending  in  1  a flag-writing op is in flight (high through its flag_we cycle inclusive).
br_valid  in  1  decode presents a branch.
br_ready  out  1  controller can accept a branch.
br_cond  in  2  00 GT (N clear), 01 LT (N set), 10 EQ (Z set), 11 ALWAYS.
br_target  in  ADDR_W  branch destination.
pc_load  out  1  one-cycle strobe: load pc_target into PC.
pc_target  out  ADDR_W  registered target.
flush  out  1  one-cycle strobe: kill younger fetched instructions.
done  out  1  one-cycle strobe: branch resolved.
taken  out  1  qualifies done: 1 taken, 0 not taken.
wait_timeout  out  1  one-cycle strobe: WAIT_LIMIT reached.

Behaviour:
- Reset: state IDLE; flags N=0, Z=0; wait counter 0; pc_target 0; br_ready=1 (IDLE decode); all strobes 0.
- Flag register: updates on any cycle with flag_we=1, in every state. Evaluation always reads the registered flags (pre-update value in the flag_we cycle).
- Outputs are decoded from the registered state only (Moore). No combinational path from inputs to outputs.
- States:
  - IDLE: br_ready=1. On br_valid: latch br_cond and br_target (pc_target updates). Next state: cond=11 -> REDIRECT; else flag_pending=1 or flag_we=1 -> WAIT_FLAGS; else EVAL.
  - WAIT_FLAGS: br_ready=0. Counter increments each cycle. flag_pending=0 -> EVAL, counter clears. Counter reaches WAIT_LIMIT while still pending -> EVAL, wait_timeout=1 in the exit cycle, counter clears.
  - EVAL: br_ready=0. Predicate true -> REDIRECT. Predicate false -> IDLE, with done=1 and taken=0 in this cycle.
  - REDIRECT: br_ready=0. pc_load=1, flush=1, done=1, taken=1 for exactly one cycle, then IDLE.
- Latency, counted from accept edge c0:
  - ALWAYS: pc_load in c1.
  - Conditional, no pending: EVAL c1; pc_load c2 if taken, or done/taken=0 in c1.
  - Each WAIT_FLAGS cycle adds 1.
- Back-to-back: a new branch is accepted only in IDLE, so minimum spacing is 2 cycles (ALWAYS) and 3 cycles (conditional taken).
- br_valid while not ready: ignored. Decode holds the request.
- br_cond/br_target changes after accept: no effect.
- Reset asserted mid-operation: immediate return to IDLE, no strobe issued, flags cleared.

Optional Feature:
COND_BRANCH_STATS_EN.
- Defined: adds 16-bit saturating counters and output ports stat_taken, stat_not_taken, stat_wait_cycles.
  - stat_taken increments on done&taken; stat_not_taken on done&~taken; stat_wait_cycles on each WAIT_FLAGS cycle.
  - All counters clear on reset and hold at 16'hFFFF.
- Undefined: no counters and no stat ports. Core behaviour identical.

Decomposition:
- Shared package: condition code constants COND_GT=2'b00, COND_LT=2'b01, COND_EQ=2'b10, COND_AL=2'b11; state encoding IDLE/WAIT_FLAGS/EVAL/REDIRECT.
- One sub-module, cond_eval: purely combinational predicate (cond, N, Z -> true). Also reused by any other conditional-execution logic.

Test Plan:
- Reset then br_valid, cond=11, target=8'h3C -> pc_load, flush, done, taken high in c1 only; pc_target=8'h3C; br_ready high again in c2.
- flag_we with N=1, then branch cond=01, target=8'h10, no pending -> EVAL c1, pc_load c2, taken=1.
- Flags N=0, Z=0; branch cond=10 -> done=1, taken=0 in c1; pc_load and flush never asserted.
- flag_pending high 4 cycles, then flag_we with Z=1 and flag_pending drop; branch cond=10 accepted during pending -> 4 WAIT_FLAGS cycles, then EVAL, then taken redirect.
- WAIT_LIMIT=3, flag_pending stuck high -> wait_timeout pulse after 3 wait cycles, then evaluation with stale flags.
- Assert reset while in WAIT_FLAGS -> outputs return to reset values immediately; no pc_load after release.
